// File: rtl/anaio_mux_ctrl_if.sv
// rtl/anaio_mux_ctrl_if.sv - requester/controller bundle for the shared analog pad mux
// master drives the request side; slave is the mux controller.
interface anaio_mux_ctrl_if #(
  parameter int N_REQ = 4
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic             enable;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] sw_en;
  logic [OW-1:0]    owner;
  logic             busy;
  logic             preempt;

  modport master (
    output enable, req,
    input  gnt, sw_en, owner, busy, preempt
  );

  modport slave (
    input  enable, req,
    output gnt, sw_en, owner, busy, preempt
  );
endinterface

// File: rtl/anaio_mux_ctrl.sv
// rtl/anaio_mux_ctrl.sv - round-robin analog pad mux sequencer with dead time, settle and hold timeout
// One counter is shared by SETTLE, GRANT (hold) and BREAK since only one of them runs at a time.
module anaio_mux_ctrl #(
  parameter int N_REQ      = 4,
  parameter int DEAD_CYC   = 2,
  parameter int SETTLE_CYC = 3,
  parameter int MAX_HOLD   = 16
) (
  input logic              clk,
  input logic              rst_n,
  anaio_mux_ctrl_if.slave  bus
);
  localparam int OW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CM1  = (SETTLE_CYC > DEAD_CYC) ? SETTLE_CYC : DEAD_CYC;
  localparam int CMAX = (CM1 > MAX_HOLD) ? CM1 : MAX_HOLD;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_GRANT  = 2'd2;
  localparam logic [1:0] S_BREAK  = 2'd3;

  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]       state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [OW-1:0]    own, own_nx;
  logic [OW-1:0]    rr_ptr, rr_nx;
  logic [OW-1:0]    winner;
  logic [N_REQ-1:0] own_mask, own_mask_nx;
  logic             owner_req, others, any_req, start, preempt_nx;

  assign own_mask  = ONE << own;
  assign owner_req = |(bus.req & own_mask);
  assign others    = |(bus.req & ~own_mask);
  assign any_req   = |bus.req;

  // Search starts at rr_ptr so the previous winner is the last one considered.
  always_comb begin
    int   idx;
    logic found;
    winner = rr_ptr;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % N_REQ;
      if (!found && bus.req[idx]) begin
        winner = OW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    own_nx     = own;
    rr_nx      = rr_ptr;
    preempt_nx = 1'b0;
    start      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.enable && any_req) start = 1'b1;
      end
      S_SETTLE: begin
        if (!owner_req || !bus.enable) begin
          state_nx = S_BREAK;
          cnt_nx   = '0;
        end else if (cnt == CW'(SETTLE_CYC - 1)) begin
          state_nx = S_GRANT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_GRANT: begin
        // A voluntary release wins over a coincident timeout, so no preempt pulse then.
        if (!owner_req || !bus.enable) begin
          state_nx = S_BREAK;
          cnt_nx   = '0;
        end else if (MAX_HOLD != 0 && others && (32'(cnt) + 1 >= MAX_HOLD)) begin
          state_nx   = S_BREAK;
          cnt_nx     = '0;
          preempt_nx = 1'b1;
        end else if (32'(cnt) < MAX_HOLD) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_BREAK: begin
        if (cnt == CW'(DEAD_CYC - 1)) begin
          if (bus.enable && any_req) begin
            start = 1'b1;
          end else begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
    if (start) begin
      state_nx = S_SETTLE;
      cnt_nx   = '0;
      own_nx   = winner;
      rr_nx    = (32'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
    end
  end

  assign own_mask_nx = ONE << own_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      own         <= '0;
      rr_ptr      <= '0;
      bus.sw_en   <= '0;
      bus.gnt     <= '0;
      bus.owner   <= '0;
      bus.busy    <= 1'b0;
      bus.preempt <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      own         <= own_nx;
      rr_ptr      <= rr_nx;
      bus.sw_en   <= (state_nx == S_SETTLE || state_nx == S_GRANT) ? own_mask_nx : '0;
      bus.gnt     <= (state_nx == S_GRANT) ? own_mask_nx : '0;
      bus.owner   <= own_nx;
      bus.busy    <= (state_nx != S_IDLE);
      bus.preempt <= preempt_nx;
    end
  end
endmodule
